fp_int_serial_mul: RTL and testbench

FP_INT_SERIAL_MUL -- requirements
Module: fp_int_serial_mul

---
 rtl/fp_int_serial_mul_if.sv | 27 ++
 rtl/fp_int_serial_mul.sv | 119 +++++++++++
 tb/tb_fp_int_serial_mul.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_int_serial_mul_if.sv
// Operand/result bundle for the serial fp16 x integer multiplier.
// The requester drives the master side and the multiplier sits on the slave side.
interface fp_int_serial_mul_if #(
   parameter int W_WIDTH   = 4,
   parameter int MAN_OUT_W = 11 + W_WIDTH
);
   logic [15:0]          activation;
   logic [W_WIDTH-1:0]   weight;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 sign_out;
   logic [4:0]           exp_out;
   logic [MAN_OUT_W-1:0] mantissa_out;
   logic                 zero_out;
   logic                 special_out;

   modport master (
      output activation, weight, start,
      input  busy, done, sign_out, exp_out, mantissa_out, zero_out, special_out
   );

   modport slave (
      input  activation, weight, start,
      output busy, done, sign_out, exp_out, mantissa_out, zero_out, special_out
   );
endinterface

// File: rtl/fp_int_serial_mul.sv
// Bit-serial fp16 significand x integer weight multiplier: one weight bit per
// cycle, MSB first, producing an unnormalised product mantissa and flags.
module fp_int_serial_mul #(
   parameter int W_WIDTH   = 4,
   parameter int SIGNED_W  = 1,
   parameter int MAN_OUT_W = 11 + W_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   fp_int_serial_mul_if.slave    bus
);
   localparam int CNT_W = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          act_q, act_d;
   logic [W_WIDTH-1:0]   w_q, w_d;
   logic [MAN_OUT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 zero_q, zero_d;

   logic                 load;
   logic [10:0]          sig;
   logic [W_WIDTH-1:0]   mag_q;
   logic [W_WIDTH-1:0]   mag_in;
   logic [W_WIDTH-1:0]   mag_shift;
   logic                 cur_bit;

   // Magnitude as W_WIDTH-bit unsigned; the most negative weight maps to 2^(W-1).
   function automatic logic [W_WIDTH-1:0] weight_mag(input logic [W_WIDTH-1:0] w);
      if (SIGNED_W != 0 && w[W_WIDTH-1])
         return ~w + 1'b1;
      else
         return w;
   endfunction

   function automatic logic weight_sign(input logic [W_WIDTH-1:0] w);
      return (SIGNED_W != 0) ? w[W_WIDTH-1] : 1'b0;
   endfunction

   assign sig       = {(act_q[14:10] != 5'd0), act_q[9:0]};
   assign mag_q     = weight_mag(w_q);
   assign mag_in    = weight_mag(bus.weight);
   assign mag_shift = mag_q << cnt_q;
   assign cur_bit   = mag_shift[W_WIDTH-1];

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      w_d     = w_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start)
               load = 1'b1;
         end
         RUN: begin
            acc_d = {acc_q[MAN_OUT_W-2:0], 1'b0}
                  + (cur_bit ? {{W_WIDTH{1'b0}}, sig} : {MAN_OUT_W{1'b0}});
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT)
               state_d = DONE;
         end
         DONE: begin
            if (bus.start)
               load = 1'b1;
            else
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flags are captured with the operands so they stay put through RUN and DONE.
      if (load) begin
         state_d = RUN;
         act_d   = bus.activation;
         w_d     = bus.weight;
         acc_d   = '0;
         cnt_d   = '0;
         zero_d  = (mag_in == '0) || (bus.activation[14:0] == 15'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         act_q   <= '0;
         w_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         w_q     <= w_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.busy         = (state_q == RUN);
   assign bus.done         = (state_q == DONE);
   assign bus.sign_out     = act_q[15] ^ weight_sign(w_q);
   assign bus.exp_out      = act_q[14:10];
   assign bus.mantissa_out = acc_q;
   assign bus.zero_out     = zero_q;
   assign bus.special_out  = (act_q[14:10] == 5'h1F);
endmodule

// File: tb/tb_fp_int_serial_mul.sv
// Directed and sweep checks of fp_int_serial_mul over six width/signedness
// configurations sharing one stimulus bus.
module tb_fp_int_serial_mul;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] act_s = '0;
   logic [7:0]  wt_s  = '0;
   logic [5:0]  start_s = '0;

   logic [5:0]  busy_v, done_v, sign_v, zero_v, spec_v;
   logic [4:0]  exp_v  [6];
   logic [18:0] mant_v [6];

   int vectors = 0;
   int miscompares = 0;

   // Index = 2*width_select + signed; width_select 0/1/2 -> W = 2/4/8.
   for (genvar gi = 0; gi < 6; gi++) begin : g_cfg
      localparam int W = (gi / 2 == 0) ? 2 : ((gi / 2 == 1) ? 4 : 8);
      localparam int S = gi % 2;

      fp_int_serial_mul_if #(.W_WIDTH(W)) bus ();

      fp_int_serial_mul #(.W_WIDTH(W), .SIGNED_W(S)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus.slave)
      );

      assign bus.activation = act_s;
      assign bus.weight     = wt_s[W-1:0];
      assign bus.start      = start_s[gi];
      assign busy_v[gi]     = bus.busy;
      assign done_v[gi]     = bus.done;
      assign sign_v[gi]     = bus.sign_out;
      assign zero_v[gi]     = bus.zero_out;
      assign spec_v[gi]     = bus.special_out;
      assign exp_v[gi]      = bus.exp_out;
      assign mant_v[gi]     = 19'(bus.mantissa_out);
   end

   // Called at a negedge; returns posedges counted until done is seen (20 = timeout).
   task automatic wait_done(input int i, input bit drop_start, output int n);
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (drop_start && n == 1) start_s[i] = 1'b0;
         if (done_v[i]) break;
      end
   endtask

   task automatic run_op(input int i, input logic [15:0] a, input logic [7:0] w, output int n);
      @(negedge clk);
      act_s = a;
      wt_s  = w;
      start_s[i] = 1'b1;
      wait_done(i, 1'b1, n);
      start_s[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if ({busy_v[i], done_v[i], sign_v[i], zero_v[i], spec_v[i], exp_v[i], mant_v[i]} !== '0) begin
            miscompares++;
            $display("FAIL reset cfg%0d: busy=%b done=%b sign=%b zero=%b spec=%b exp=%0d mant=%h, required all 0",
                     i, busy_v[i], done_v[i], sign_v[i], zero_v[i], spec_v[i], exp_v[i], mant_v[i]);
         end
      end
      rst = 1'b0;
      $display("reset: all configurations checked");
   endtask

   task automatic test_unsigned();
      int n;
      run_op(2, 16'h3C00, 8'h5, n);
      vectors += 5;
      if (n !== 5) begin miscompares++; $display("FAIL unsigned latency: got %0d required 5", n); end
      if (mant_v[2] !== 19'h1400) begin miscompares++; $display("FAIL unsigned mant: got %h required 1400", mant_v[2]); end
      if (exp_v[2] !== 5'd15) begin miscompares++; $display("FAIL unsigned exp: got %0d required 15", exp_v[2]); end
      if (sign_v[2] !== 1'b0) begin miscompares++; $display("FAIL unsigned sign: got %b required 0", sign_v[2]); end
      if (zero_v[2] !== 1'b0) begin miscompares++; $display("FAIL unsigned zero: got %b required 0", zero_v[2]); end
      $display("unsigned: 3C00 x 5 -> mant=%h exp=%0d lat=%0d", mant_v[2], exp_v[2], n);
   endtask

   task automatic test_signed();
      int n;
      run_op(3, 16'h3E00, 8'h8, n);
      vectors += 2;
      if (mant_v[3] !== 19'h3000) begin miscompares++; $display("FAIL signed_neg8 mant: got %h required 3000", mant_v[3]); end
      if (sign_v[3] !== 1'b1) begin miscompares++; $display("FAIL signed_neg8 sign: got %b required 1", sign_v[3]); end
      $display("signed: 3E00 x -8 -> mant=%h sign=%b", mant_v[3], sign_v[3]);
      run_op(3, 16'hBC00, 8'hF, n);
      vectors += 2;
      if (mant_v[3] !== 19'h0400) begin miscompares++; $display("FAIL signed_neg1 mant: got %h required 0400", mant_v[3]); end
      if (sign_v[3] !== 1'b0) begin miscompares++; $display("FAIL signed_neg1 sign: got %b required 0", sign_v[3]); end
      $display("signed: BC00 x -1 -> mant=%h sign=%b", mant_v[3], sign_v[3]);
   endtask

   task automatic test_zero_sub_special();
      int n;
      run_op(2, 16'h0000, 8'h7, n);
      vectors += 2;
      if (zero_v[2] !== 1'b1) begin miscompares++; $display("FAIL zero flag: got %b required 1", zero_v[2]); end
      if (mant_v[2] !== 19'h0) begin miscompares++; $display("FAIL zero mant: got %h required 0", mant_v[2]); end
      $display("zero: 0000 x 7 -> zero=%b mant=%h", zero_v[2], mant_v[2]);
      run_op(2, 16'h0001, 8'h3, n);
      vectors += 3;
      if (mant_v[2] !== 19'h3) begin miscompares++; $display("FAIL subnormal mant: got %h required 3", mant_v[2]); end
      if (exp_v[2] !== 5'd0) begin miscompares++; $display("FAIL subnormal exp: got %0d required 0", exp_v[2]); end
      if (zero_v[2] !== 1'b0) begin miscompares++; $display("FAIL subnormal zero: got %b required 0", zero_v[2]); end
      $display("subnormal: 0001 x 3 -> mant=%h exp=%0d", mant_v[2], exp_v[2]);
      run_op(2, 16'h7C00, 8'h1, n);
      vectors += 3;
      if (spec_v[2] !== 1'b1) begin miscompares++; $display("FAIL special flag: got %b required 1", spec_v[2]); end
      if (mant_v[2] !== 19'h400) begin miscompares++; $display("FAIL special mant: got %h required 400", mant_v[2]); end
      if (exp_v[2] !== 5'd31) begin miscompares++; $display("FAIL special exp: got %0d required 31", exp_v[2]); end
      $display("special: 7C00 x 1 -> spec=%b mant=%h", spec_v[2], mant_v[2]);
   endtask

   task automatic test_start_held();
      int n;
      @(negedge clk);
      act_s = 16'h3C00;
      wt_s  = 8'h5;
      start_s[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      act_s = 16'h4000;
      wt_s  = 8'h3;
      wait_done(2, 1'b0, n);
      start_s[2] = 1'b0;
      vectors += 3;
      if (n + 1 !== 5) begin miscompares++; $display("FAIL held latency: got %0d required 5", n + 1); end
      if (mant_v[2] !== 19'h1400) begin miscompares++; $display("FAIL held mant: got %h required 1400", mant_v[2]); end
      if (exp_v[2] !== 5'd15) begin miscompares++; $display("FAIL held exp: got %0d required 15", exp_v[2]); end
      @(negedge clk);
      vectors += 2;
      if ({busy_v[2], done_v[2]} !== 2'b00) begin miscompares++; $display("FAIL held idle: busy/done=%b required 00", {busy_v[2], done_v[2]}); end
      if (mant_v[2] !== 19'h1400) begin miscompares++; $display("FAIL held hold mant: got %h required 1400", mant_v[2]); end
      $display("start held in RUN: mant=%h lat=%0d", mant_v[2], n + 1);
   endtask

   task automatic test_back_to_back();
      logic [15:0] acts [3] = '{16'h3C00, 16'h4000, 16'h3555};
      logic [7:0]  wts  [3] = '{8'h5, 8'h3, 8'h2};
      logic [18:0] exps [3] = '{19'h1400, 19'h0C00, 19'h0AAA};
      int n;
      @(negedge clk);
      start_s[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         act_s = acts[k];
         wt_s  = wts[k];
         wait_done(2, 1'b0, n);
         vectors += 2;
         if (n !== 5) begin miscompares++; $display("FAIL b2b%0d period: got %0d required 5", k, n); end
         if (mant_v[2] !== exps[k]) begin miscompares++; $display("FAIL b2b%0d mant: got %h required %h", k, mant_v[2], exps[k]); end
         $display("back-to-back %0d: %h x %0d -> mant=%h period=%0d", k, acts[k], wts[k], mant_v[2], n);
      end
      start_s[2] = 1'b0;
      @(negedge clk);
      vectors += 2;
      if ({busy_v[2], done_v[2]} !== 2'b00) begin miscompares++; $display("FAIL b2b idle: busy/done=%b required 00", {busy_v[2], done_v[2]}); end
      if (mant_v[2] !== 19'h0AAA) begin miscompares++; $display("FAIL b2b hold mant: got %h required aaa", mant_v[2]); end
   endtask

   task automatic test_reset_mid();
      int n;
      bit seen;
      @(negedge clk);
      act_s = 16'h3C00;
      wt_s  = 8'h5;
      start_s[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({busy_v[2], done_v[2], sign_v[2], zero_v[2], spec_v[2], exp_v[2], mant_v[2]} !== '0) begin
         miscompares++;
         $display("FAIL midreset outputs: busy=%b done=%b exp=%0d mant=%h, required all 0",
                  busy_v[2], done_v[2], exp_v[2], mant_v[2]);
      end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done_v[2]) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin miscompares++; $display("FAIL midreset done: got pulse, required none"); end
      start_s[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[2] = 1'b0;
      vectors++;
      if (busy_v[2] !== 1'b1) begin miscompares++; $display("FAIL post-reset accept: busy=%b required 1", busy_v[2]); end
      wait_done(2, 1'b0, n);
      vectors++;
      if (mant_v[2] !== 19'h1400) begin miscompares++; $display("FAIL post-reset mant: got %h required 1400", mant_v[2]); end
      $display("reset mid-RUN: aborted, restart mant=%h", mant_v[2]);
   endtask

   task automatic test_sweep(input int i, input int w, input int s);
      int n, errs_before;
      logic [15:0] a;
      int sig, mag, prod;
      bit wsign, zexp;
      errs_before = miscompares;
      for (int wv = 0; wv < (1 << w); wv++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 7) == 0) a[14:10] = 5'd0;
         run_op(i, a, 8'(wv), n);
         sig   = ((a[14:10] != 5'd0) ? 1024 : 0) + int'(a[9:0]);
         wsign = (s != 0) && (wv >= (1 << (w - 1)));
         mag   = wsign ? (1 << w) - wv : wv;
         prod  = sig * mag;
         zexp  = (mag == 0) || (a[14:0] == 15'd0);
         vectors += 4;
         if (n !== w + 1) begin miscompares++; $display("FAIL sweep cfg%0d w=%0d latency: got %0d required %0d", i, wv, n, w + 1); end
         if (mant_v[i] !== 19'(prod)) begin miscompares++; $display("FAIL sweep cfg%0d act=%h w=%0d mant: got %h required %h", i, a, wv, mant_v[i], 19'(prod)); end
         if (sign_v[i] !== (a[15] ^ wsign)) begin miscompares++; $display("FAIL sweep cfg%0d act=%h w=%0d sign: got %b required %b", i, a, wv, sign_v[i], a[15] ^ wsign); end
         if (zero_v[i] !== zexp) begin miscompares++; $display("FAIL sweep cfg%0d act=%h w=%0d zero: got %b required %b", i, a, wv, zero_v[i], zexp); end
      end
      $display("sweep W=%0d SIGNED=%0d: %0d weights, %0d new miscompares", w, s, 1 << w, miscompares - errs_before);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_zero_sub_special();
      test_start_held();
      test_back_to_back();
      test_reset_mid();
      test_sweep(0, 2, 0);
      test_sweep(1, 2, 1);
      test_sweep(2, 4, 0);
      test_sweep(3, 4, 1);
      test_sweep(4, 8, 0);
      test_sweep(5, 8, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
